// File: rtl/imem_port0_arbiter.sv
// Port-0 owner for the 32x512 instruction SRAM: arbitrates Wishbone and LA-loader
// accesses and holds the CTRL register that keeps the core in reset during load.
module imem_port0_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          RD_LAT    = 1,
  parameter int          ADDR_W    = 9
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              la_req_i,
  input  logic              la_we_i,
  input  logic [ADDR_W-1:0] la_addr_i,
  input  logic [31:0]       la_wdata_i,
  output logic              la_ack_o,
  output logic [31:0]       la_rdata_o,
  output logic              sram_csb0_o,
  output logic              sram_web0_o,
  output logic [3:0]        sram_wmask0_o,
  output logic [ADDR_W-1:0] sram_addr0_o,
  output logic [31:0]       sram_din0_o,
  input  logic [31:0]       sram_dout0_i,
  output logic              core_reset_o,
  output logic              busy_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RDWAIT = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [1:0] K_SRAM = 2'd0;
  localparam logic [1:0] K_CTRL = 2'd1;
  localparam logic [1:0] K_NONE = 2'd2;

  localparam logic SRC_WB = 1'b0;
  localparam logic SRC_LA = 1'b1;

  // RD_LAT is expected to be at least 1; the counter holds RD_LAT-1 down to 0.
  localparam int              CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

  logic [1:0]        state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic              src_q, src_d;
  logic [1:0]        kind_q, kind_d;
  logic              abort_q, abort_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hold_q, hold_d;
  logic              la_en_q, la_en_d;
  logic              req_we_q, req_we_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [31:0]       req_wdata_q, req_wdata_d;
  logic [3:0]        req_mask_q, req_mask_d;
  logic              wbs_ack_q, wbs_ack_d;
  logic [31:0]       wbs_dat_q, wbs_dat_d;
  logic              la_ack_q, la_ack_d;
  logic [31:0]       la_rdata_q, la_rdata_d;
  logic              sram_csb_q, sram_csb_d;
  logic              sram_web_q, sram_web_d;
  logic [3:0]        sram_wmask_q, sram_wmask_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [31:0]       sram_din_q, sram_din_d;
  logic              busy_q, busy_d;

  logic        wb_hit, la_elig, grant_wb, grant_la, live;
  logic [1:0]  wb_kind;
  logic [31:0] rd_val;
  logic        unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];

  assign wb_hit   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  assign wb_kind  = !wbs_adr_i[11] ? K_SRAM :
                    (wbs_adr_i[11:2] == 10'h200) ? K_CTRL : K_NONE;
  assign la_elig  = la_req_i & la_en_q;
  // rr_last only matters under contention; a sole requester always wins.
  assign grant_wb = wb_hit & (!la_elig | (rr_last_q == SRC_LA));
  assign grant_la = la_elig & !grant_wb;
  assign live     = (src_q == SRC_WB) ? wbs_cyc_i : la_req_i;

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    src_d       = src_q;
    kind_d      = kind_q;
    abort_d     = abort_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    la_en_d     = la_en_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_mask_d  = req_mask_q;
    wbs_ack_d   = 1'b0;
    wbs_dat_d   = wbs_dat_q;
    la_ack_d    = 1'b0;
    la_rdata_d  = la_rdata_q;
    rd_val      = 32'h0;

    case (state_q)
      S_IDLE: begin
        if (grant_wb | grant_la) begin
          if (wb_hit & la_elig) rr_last_d = grant_wb ? SRC_WB : SRC_LA;
          abort_d = 1'b0;
          if (grant_wb) begin
            src_d       = SRC_WB;
            kind_d      = wb_kind;
            req_we_d    = wbs_we_i;
            req_addr_d  = wbs_adr_i[ADDR_W+1:2];
            req_wdata_d = wbs_dat_i;
            req_mask_d  = wbs_we_i ? wbs_sel_i : 4'h0;
          end else begin
            src_d       = SRC_LA;
            kind_d      = K_SRAM;
            req_we_d    = la_we_i;
            req_addr_d  = la_addr_i;
            req_wdata_d = la_wdata_i;
            req_mask_d  = la_we_i ? 4'hF : 4'h0;
          end
          state_d = (kind_d == K_SRAM) ? S_ACCESS : S_DONE;
        end
      end
      S_ACCESS: begin
        abort_d = abort_q | !live;
        cnt_d   = CNT_INIT;
        state_d = req_we_q ? S_DONE : S_RDWAIT;
      end
      S_RDWAIT: begin
        abort_d = abort_q | !live;
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Everything the DONE cycle presents is computed on the edge that enters it.
    if ((state_q != S_DONE) && (state_d == S_DONE)) begin
      if (kind_d == K_SRAM)      rd_val = sram_dout0_i;
      else if (kind_d == K_CTRL) rd_val = {30'h0, la_en_q, hold_q};
      if ((kind_d == K_CTRL) && req_we_d && req_mask_d[0]) begin
        hold_d  = req_wdata_d[0];
        la_en_d = req_wdata_d[1];
      end
      if (!abort_d) begin
        if (src_d == SRC_WB) begin
          wbs_ack_d = 1'b1;
          if (!req_we_d) wbs_dat_d = rd_val;
        end else begin
          la_ack_d = 1'b1;
          if (!req_we_d) la_rdata_d = rd_val;
        end
      end
    end

    sram_csb_d   = (state_d != S_ACCESS);
    sram_web_d   = !((state_d == S_ACCESS) && req_we_d);
    sram_wmask_d = (state_d == S_ACCESS) ? req_mask_d  : 4'h0;
    sram_addr_d  = (state_d == S_ACCESS) ? req_addr_d  : sram_addr_q;
    sram_din_d   = (state_d == S_ACCESS) ? req_wdata_d : sram_din_q;
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= S_IDLE;
      rr_last_q    <= SRC_LA;
      src_q        <= SRC_WB;
      kind_q       <= K_NONE;
      abort_q      <= 1'b0;
      cnt_q        <= '0;
      hold_q       <= 1'b1;
      la_en_q      <= 1'b0;
      wbs_ack_q    <= 1'b0;
      wbs_dat_q    <= 32'h0;
      la_ack_q     <= 1'b0;
      la_rdata_q   <= 32'h0;
      sram_csb_q   <= 1'b1;
      sram_web_q   <= 1'b1;
      sram_wmask_q <= 4'h0;
      sram_addr_q  <= '0;
      sram_din_q   <= 32'h0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_last_q    <= rr_last_d;
      src_q        <= src_d;
      kind_q       <= kind_d;
      abort_q      <= abort_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      la_en_q      <= la_en_d;
      wbs_ack_q    <= wbs_ack_d;
      wbs_dat_q    <= wbs_dat_d;
      la_ack_q     <= la_ack_d;
      la_rdata_q   <= la_rdata_d;
      sram_csb_q   <= sram_csb_d;
      sram_web_q   <= sram_web_d;
      sram_wmask_q <= sram_wmask_d;
      sram_addr_q  <= sram_addr_d;
      sram_din_q   <= sram_din_d;
      busy_q       <= busy_d;
    end
  end

  // Latched request fields are only consumed after a grant, so they need no reset.
  always_ff @(posedge wb_clk_i) begin
    req_we_q    <= req_we_d;
    req_addr_q  <= req_addr_d;
    req_wdata_q <= req_wdata_d;
    req_mask_q  <= req_mask_d;
  end

  assign wbs_ack_o     = wbs_ack_q;
  assign wbs_dat_o     = wbs_dat_q;
  assign la_ack_o      = la_ack_q;
  assign la_rdata_o    = la_rdata_q;
  assign sram_csb0_o   = sram_csb_q;
  assign sram_web0_o   = sram_web_q;
  assign sram_wmask0_o = sram_wmask_q;
  assign sram_addr0_o  = sram_addr_q;
  assign sram_din0_o   = sram_din_q;
  assign core_reset_o  = hold_q;
  assign busy_o        = busy_q;

endmodule
